flit_link_tx: RTL and testbench

- Transmit end of a router link. Drains an upstream input-buffer FIFO through its push/pop interface. The FIFO is first-word-fall-through: dout is valid while empty=0.
- Sends flits to the downstream router's input FIFO using credit-based flow control.
- Enforces wormhole packet framing: a new packet starts only when tx_en is high, and a started packet always runs to its tail.

---
 rtl/flit_link_tx.sv | 195 +++++++++++++++++++
 tb/tb_flit_link_tx.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/flit_link_tx.sv
// ---------------------------------------------------------------------------
// flit_link_tx
// Transmit end of a router link. Pulls flits from a first-word-fall-through
// upstream FIFO and forwards them on a registered link to the downstream
// router. Credit-based flow control keeps the downstream input FIFO from
// overflowing. Wormhole framing lets a new packet start only while tx_en is
// high, and a packet that has started always runs to its tail.
//
// Parameters:
//   DEPTH_BITS  log2 of the downstream FIFO depth (credits reset to 2**DEPTH_BITS)
//   DATA_WIDTH  flit width; the type field is bits [DATA_WIDTH-1:DATA_WIDTH-2]
//
// Ports:
//   clk         rising-edge clock
//   reset       asynchronous active-low reset
//   fifo_empty  upstream FIFO empty
//   fifo_dout   upstream FIFO head flit (valid while fifo_empty=0)
//   fifo_pop    pop the upstream FIFO (combinational, equals send)
//   tx_en       permit starting new packets
//   link_valid  registered flit-valid toward downstream
//   link_data   registered flit toward downstream (holds when idle)
//   credit_in   one credit returned by downstream
//   credits     current credit count
//   in_packet   high while a packet is in progress (state ACTIVE)
//   flit_count  (FLIT_LINK_TX_STATS_EN only) number of flits sent, wraps
//   pkt_count   (FLIT_LINK_TX_STATS_EN only) number of packet tails sent, wraps
//   credit_err  sticky credit overflow flag
//
// Optional feature macro: FLIT_LINK_TX_STATS_EN adds the flit_count and
// pkt_count statistics outputs. Without it those ports and their logic are
// absent and the rest of the behaviour is unchanged.
// ---------------------------------------------------------------------------
module flit_link_tx #(
   parameter int DEPTH_BITS = 3,
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  fifo_empty,
   input  logic [DATA_WIDTH-1:0] fifo_dout,
   output logic                  fifo_pop,
   input  logic                  tx_en,
   output logic                  link_valid,
   output logic [DATA_WIDTH-1:0] link_data,
   input  logic                  credit_in,
   output logic [DEPTH_BITS:0]   credits,
   output logic                  in_packet,
`ifdef FLIT_LINK_TX_STATS_EN
   output logic [31:0]           flit_count,
   output logic [31:0]           pkt_count,
`endif
   output logic                  credit_err
);

   localparam logic [DEPTH_BITS:0] CREDIT_MAX = {1'b1, {DEPTH_BITS{1'b0}}};

   localparam logic [1:0] TYPE_BODY      = 2'b00;
   localparam logic [1:0] TYPE_HEAD      = 2'b01;
   localparam logic [1:0] TYPE_TAIL      = 2'b10;
   localparam logic [1:0] TYPE_HEAD_TAIL = 2'b11;

   typedef enum logic {
      IDLE   = 1'b0,
      ACTIVE = 1'b1
   } state_t;

   state_t                state_q, state_d;
   logic [DEPTH_BITS:0]   credits_q, credits_d;
   logic                  credit_err_q, credit_err_d;
   logic                  link_valid_q, link_valid_d;
   logic [DATA_WIDTH-1:0] link_data_q, link_data_d;
   logic                  send;
   logic [1:0]            flit_type;

   assign flit_type = fifo_dout[DATA_WIDTH-1:DATA_WIDTH-2];

   // A flit leaves only with a credit in hand, and only if it either belongs
   // to the packet already in flight or tx_en allows a new packet to begin.
   // Gating with reset keeps fifo_pop low for the whole reset assertion.
   always_comb begin
      send = reset && !fifo_empty && (credits_q != '0) &&
             ((state_q == ACTIVE) || tx_en);
   end

   assign fifo_pop = send;

   // Credit bookkeeping: a send consumes one, a returned credit adds one.
   // A return with no send while already full would exceed the downstream
   // FIFO depth, so the count saturates and the sticky error flag is raised.
   always_comb begin
      credits_d    = credits_q;
      credit_err_d = credit_err_q;
      case ({send, credit_in})
         2'b10: credits_d = credits_q - 1'b1;
         2'b01: begin
            if (credits_q == CREDIT_MAX) begin
               credit_err_d = 1'b1;
            end else begin
               credits_d = credits_q + 1'b1;
            end
         end
         default: credits_d = credits_q;
      endcase
   end

   // Packet framing. The state only moves on a send; stray BODY/TAIL flits
   // seen while IDLE are forwarded untouched and leave the state IDLE, and a
   // HEAD seen mid-packet is simply treated as the start of a new packet.
   always_comb begin
      state_d = state_q;
      if (send) begin
         case (state_q)
            IDLE: begin
               if (flit_type == TYPE_HEAD) begin
                  state_d = ACTIVE;
               end else begin
                  state_d = IDLE;
               end
            end
            ACTIVE: begin
               if ((flit_type == TYPE_TAIL) || (flit_type == TYPE_HEAD_TAIL)) begin
                  state_d = IDLE;
               end else begin
                  state_d = ACTIVE;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   // Link output register: one cycle of latency from pop to link, and the
   // data bus keeps the last flit sent when nothing new goes out.
   always_comb begin
      link_valid_d = send;
      link_data_d  = link_data_q;
      if (send) begin
         link_data_d = fifo_dout;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= IDLE;
         credits_q    <= CREDIT_MAX;
         credit_err_q <= 1'b0;
         link_valid_q <= 1'b0;
         link_data_q  <= '0;
      end else begin
         state_q      <= state_d;
         credits_q    <= credits_d;
         credit_err_q <= credit_err_d;
         link_valid_q <= link_valid_d;
         link_data_q  <= link_data_d;
      end
   end

   assign link_valid = link_valid_q;
   assign link_data  = link_data_q;
   assign credits    = credits_q;
   assign credit_err = credit_err_q;
   assign in_packet  = (state_q == ACTIVE);

`ifdef FLIT_LINK_TX_STATS_EN
   logic [31:0] flit_count_q, flit_count_d;
   logic [31:0] pkt_count_q, pkt_count_d;

   // Statistics: every send is a flit; a packet is counted when its last
   // flit (TAIL or HEAD_TAIL) goes out. Both wrap naturally at 2**32.
   always_comb begin
      flit_count_d = flit_count_q;
      pkt_count_d  = pkt_count_q;
      if (send) begin
         flit_count_d = flit_count_q + 32'd1;
         if ((flit_type == TYPE_TAIL) || (flit_type == TYPE_HEAD_TAIL)) begin
            pkt_count_d = pkt_count_q + 32'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         flit_count_q <= '0;
         pkt_count_q  <= '0;
      end else begin
         flit_count_q <= flit_count_d;
         pkt_count_q  <= pkt_count_d;
      end
   end

   assign flit_count = flit_count_q;
   assign pkt_count  = pkt_count_q;
`endif

endmodule

// File: tb/tb_flit_link_tx.sv
// ---------------------------------------------------------------------------
// tb_flit_link_tx
// Directed bench for flit_link_tx. A queue models the upstream FWFT FIFO;
// every flit loaded into it is also pushed to a scoreboard, and a monitor
// compares each flit that appears on the link against the scoreboard head.
// ---------------------------------------------------------------------------
module tb_flit_link_tx;

   localparam int DEPTH_BITS = 3;
   localparam int DATA_WIDTH = 32;

   logic                  clk;
   logic                  reset;
   logic                  fifo_empty;
   logic [DATA_WIDTH-1:0] fifo_dout;
   logic                  fifo_pop;
   logic                  tx_en;
   logic                  link_valid;
   logic [DATA_WIDTH-1:0] link_data;
   logic                  credit_in;
   logic [DEPTH_BITS:0]   credits;
   logic                  in_packet;
   logic                  credit_err;
`ifdef FLIT_LINK_TX_STATS_EN
   logic [31:0]           flit_count;
   logic [31:0]           pkt_count;
`endif

   int tests_run = 0;
   int tests_failed = 0;

   logic [DATA_WIDTH-1:0] fifo_q[$];
   logic [DATA_WIDTH-1:0] exp_q[$];

   flit_link_tx #(
      .DEPTH_BITS(DEPTH_BITS),
      .DATA_WIDTH(DATA_WIDTH)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .fifo_empty (fifo_empty),
      .fifo_dout  (fifo_dout),
      .fifo_pop   (fifo_pop),
      .tx_en      (tx_en),
      .link_valid (link_valid),
      .link_data  (link_data),
      .credit_in  (credit_in),
      .credits    (credits),
      .in_packet  (in_packet),
`ifdef FLIT_LINK_TX_STATS_EN
      .flit_count (flit_count),
      .pkt_count  (pkt_count),
`endif
      .credit_err (credit_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [DATA_WIDTH-1:0] mk_flit(input logic [1:0] t, input int n);
      logic [DATA_WIDTH-3:0] payload;
      payload = (DATA_WIDTH-2)'(n);
      return {t, payload};
   endfunction

   // Present the queue head as an FWFT FIFO output.
   function automatic void refresh_fifo();
      fifo_empty = (fifo_q.size() == 0);
      fifo_dout  = (fifo_q.size() != 0) ? fifo_q[0] : '0;
   endfunction

   task automatic push_flit(input logic [1:0] t, input int n);
      logic [DATA_WIDTH-1:0] f;
      f = mk_flit(t, n);
      fifo_q.push_back(f);
      exp_q.push_back(f);
      refresh_fifo();
   endtask

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests_run++;
      assert (obs === exp) else begin
         tests_failed++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Upstream FIFO model: the pop decision is taken at the edge, the queue
   // advances just after it so the DUT samples the old head.
   always @(posedge clk) begin
      if (fifo_pop === 1'b1) begin
         #1;
         if (fifo_q.size() != 0) void'(fifo_q.pop_front());
         refresh_fifo();
      end
   end

   // Link monitor: every valid flit must match the scoreboard head.
   always @(negedge clk) begin
      if (reset === 1'b1 && link_valid === 1'b1) begin
         if (exp_q.size() == 0) begin
            check_val("unexpected_flit", link_data, 32'hDEAD_BEEF);
         end else begin
            check_val("link_data", link_data, exp_q.pop_front());
         end
      end
   end

   initial begin
      reset     = 1'b0;
      tx_en     = 1'b1;
      credit_in = 1'b0;
      refresh_fifo();

      // Reset state, with a full packet already waiting upstream
      push_flit(2'b01, 100);
      for (int i = 0; i < 8; i++) push_flit(2'b00, 101 + i);
      push_flit(2'b10, 109);
      #12;
      check_val("rst_link_valid", 32'(link_valid), 32'd0);
      check_val("rst_link_data",  link_data, 32'd0);
      check_val("rst_credits",    32'(credits), 32'd8);
      check_val("rst_in_packet",  32'(in_packet), 32'd0);
      check_val("rst_credit_err", 32'(credit_err), 32'd0);
      check_val("rst_fifo_pop",   32'(fifo_pop), 32'd0);

      // Credit exhaustion: 8 consecutive flits, then stall mid-packet
      @(negedge clk);
      reset = 1'b1;
      #1;
      check_val("pop_after_rst", 32'(fifo_pop), 32'd1);
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         check_val("exhaust_valid", 32'(link_valid), 32'd1);
      end
      check_val("exhaust_credits", 32'(credits), 32'd0);
      check_val("exhaust_pop",     32'(fifo_pop), 32'd0);
      check_val("exhaust_inpkt",   32'(in_packet), 32'd1);
      @(negedge clk);
      check_val("exhaust_bubble",  32'(link_valid), 32'd0);

      // Credit return resumes the packet one flit per credit
      credit_in = 1'b1;
      @(negedge clk);
      credit_in = 1'b0;
      check_val("ret1_credits", 32'(credits), 32'd1);
      check_val("ret1_pop",     32'(fifo_pop), 32'd1);
      @(negedge clk);
      check_val("ret1_sent_credits", 32'(credits), 32'd0);
      check_val("ret1_sent_valid",   32'(link_valid), 32'd1);
      credit_in = 1'b1;
      @(negedge clk);
      credit_in = 1'b0;
      @(negedge clk);
      check_val("tail_valid",   32'(link_valid), 32'd1);
      check_val("tail_inpkt",   32'(in_packet), 32'd0);
      check_val("tail_credits", 32'(credits), 32'd0);

      // Refill to full; no overflow yet
      credit_in = 1'b1;
      repeat (8) @(negedge clk);
      credit_in = 1'b0;
      check_val("refill_credits", 32'(credits), 32'd8);
      check_val("refill_err",     32'(credit_err), 32'd0);

      // Credit overflow saturates and latches the error
      credit_in = 1'b1;
      @(negedge clk);
      credit_in = 1'b0;
      check_val("ovf_credits", 32'(credits), 32'd8);
      check_val("ovf_err",     32'(credit_err), 32'd1);
      repeat (5) @(negedge clk);
      check_val("ovf_sticky",  32'(credit_err), 32'd1);

      // tx_en gating: packet in flight finishes, next packet waits
      push_flit(2'b01, 200);
      @(negedge clk);
      check_val("gate_head_valid", 32'(link_valid), 32'd1);
      tx_en = 1'b0;
      push_flit(2'b00, 201);
      push_flit(2'b10, 202);
      push_flit(2'b11, 203);
      @(negedge clk);
      check_val("gate_body_valid", 32'(link_valid), 32'd1);
      @(negedge clk);
      check_val("gate_tail_valid", 32'(link_valid), 32'd1);
      check_val("gate_idle",       32'(in_packet), 32'd0);
      repeat (3) begin
         @(negedge clk);
         check_val("gate_hold_valid", 32'(link_valid), 32'd0);
         check_val("gate_hold_pop",   32'(fifo_pop), 32'd0);
      end
      tx_en = 1'b1;
      #1;
      check_val("gate_release_pop", 32'(fifo_pop), 32'd1);
      @(negedge clk);
      check_val("gate_ht_valid",   32'(link_valid), 32'd1);
      check_val("gate_ht_credits", 32'(credits), 32'd4);
      check_val("gate_ht_inpkt",   32'(in_packet), 32'd0);

      // Simultaneous send and credit return at credits=4
      push_flit(2'b01, 300);
      credit_in = 1'b1;
      @(negedge clk);
      credit_in = 1'b0;
      check_val("simul_credits", 32'(credits), 32'd4);
      check_val("simul_valid",   32'(link_valid), 32'd1);
      check_val("simul_inpkt",   32'(in_packet), 32'd1);
      push_flit(2'b00, 301);
      @(negedge clk);
      check_val("pre_rst_credits", 32'(credits), 32'd3);
      check_val("pre_rst_inpkt",   32'(in_packet), 32'd1);

      // Asynchronous reset mid-packet, between clock edges
      #2;
      reset = 1'b0;
      #1;
      check_val("arst_link_valid", 32'(link_valid), 32'd0);
      check_val("arst_credits",    32'(credits), 32'd8);
      check_val("arst_inpkt",      32'(in_packet), 32'd0);
      check_val("arst_credit_err", 32'(credit_err), 32'd0);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check_val("post_rst_credits", 32'(credits), 32'd8);
      check_val("scoreboard_empty", 32'(exp_q.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
